// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: op encodings, FSM states
// and the instruction-size helper.
package seq_pkg;

  typedef enum logic [2:0] {
    OP_NEXT       = 3'd0,
    OP_JUMP       = 3'd1,
    OP_BRANCH_REL = 3'd2,
    OP_CALL       = 3'd3,
    OP_RET        = 3'd4
  } op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  // A zero-length instruction field still has to move the pc forward.
  localparam logic [1:0] INSTR_SIZE_DEFAULT = 2'd1;

  function automatic logic [1:0] eff_size(input logic [1:0] size);
    return (size == 2'd0) ? INSTR_SIZE_DEFAULT : size;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Parametrised LIFO holding return addresses; pushes when full and pops when
// empty are dropped without touching contents or count.
module pc_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // When full, wr_idx wraps but is never used for a write; rd_idx stays valid.
  assign wr_idx   = count[IDX_W-1:0];
  assign rd_idx   = wr_idx - IDX_W'(1);
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign top_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst_n && push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter sequencer with return stack and sticky stack-error fault.
//   state    | meaning
//   ST_RUN   | executing ops on each adv strobe
//   ST_FAULT | stack error seen; pc and stack frozen until err_clr
module program_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             adv,
  input  logic [2:0]                       op,
  input  logic                             cond,
  input  logic [ADDR_WIDTH-1:0]            target_addr,
  input  logic [ADDR_WIDTH-1:0]            rel_offset,
  input  logic [1:0]                       instr_size,
  input  logic                             err_clr,
  output logic [ADDR_WIDTH-1:0]            pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             fault,
  output logic                             stack_ovf,
  output logic                             stack_udf
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [ADDR_WIDTH-1:0] seq;
  logic [ADDR_WIDTH-1:0] top_data;
  logic                  ovf_nxt, udf_nxt;
  logic                  push, pop;
  logic                  stk_full, stk_empty;

  assign seq   = pc + ADDR_WIDTH'(eff_size(instr_size));
  assign fault = (state == ST_FAULT);

  pc_return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH),
    .CNT_W (SP_W)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .top_data  (top_data),
    .full      (stk_full),
    .empty     (stk_empty),
    .count     (sp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      pc        <= '0;
      stack_ovf <= 1'b0;
      stack_udf <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      stack_ovf <= ovf_nxt;
      stack_udf <= udf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ovf_nxt   = stack_ovf;
    udf_nxt   = stack_udf;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_RUN: begin
        // Clear first so an error raised by this same op wins.
        if (err_clr) begin
          ovf_nxt = 1'b0;
          udf_nxt = 1'b0;
        end
        if (adv) begin
          case (op)
            OP_JUMP:       pc_nxt = cond ? target_addr : seq;
            OP_BRANCH_REL: pc_nxt = cond ? (seq + rel_offset) : seq;
            OP_CALL: begin
              if (stk_full) begin
                ovf_nxt   = 1'b1;
                state_nxt = ST_FAULT;
              end else begin
                push   = 1'b1;
                pc_nxt = target_addr;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                udf_nxt   = 1'b1;
                state_nxt = ST_FAULT;
              end else begin
                pop    = 1'b1;
                pc_nxt = top_data;
              end
            end
            default:       pc_nxt = seq;
          endcase
        end
      end
      ST_FAULT: begin
        if (err_clr) begin
          ovf_nxt   = 1'b0;
          udf_nxt   = 1'b0;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of every address, offset and return-stack entry.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-stack entries; legal range 2..16.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 adv  in  1  advance strobe; when low, all state holds.
REQ-006 op  in  3  sequencing operation: NEXT=0, JUMP=1, BRANCH_REL=2, CALL=3, RET=4; values 5..7 are reserved.
REQ-007 cond  in  1  taken qualifier for JUMP and BRANCH_REL.
REQ-008 target_addr  in  ADDR_WIDTH  absolute target for JUMP and CALL.
REQ-009 rel_offset  in  ADDR_WIDTH  two's-complement offset for BRANCH_REL.
REQ-010 instr_size  in  2  current instruction length in bytes; 0 is treated as 1.
REQ-011 err_clr  in  1  clears the fault state and the sticky flags.
REQ-012 pc  out  ADDR_WIDTH  current program counter (registered).
REQ-013 sp  out  clog2(STACK_DEPTH+1)  number of valid return-stack entries.
REQ-014 fault  out  1  high while the FSM is in FAULT.
REQ-015 stack_ovf  out  1  sticky flag: CALL was attempted with the stack full.
REQ-016 stack_udf  out  1  sticky flag: RET was attempted with the stack empty.

Function
REQ-017 The block SHALL define seq = pc + instr_size (0 treated as 1), computed modulo 2^ADDR_WIDTH so it wraps silently.
REQ-018 The FSM SHALL have two states, RUN and FAULT; in FAULT, pc and the stack hold regardless of adv or op.
REQ-019 In RUN with adv=0, all registers SHALL hold.
REQ-020 In RUN with adv=1 and op=NEXT or a reserved value, the block SHALL set pc <= seq.
REQ-021 For JUMP, the block SHALL set pc <= target_addr if cond=1, else pc <= seq.
REQ-022 For BRANCH_REL, the block SHALL set pc <= seq + rel_offset (modulo 2^ADDR_WIDTH) if cond=1, else pc <= seq.
REQ-023 For CALL with sp<STACK_DEPTH, the block SHALL push seq, increment sp and set pc <= target_addr; cond is ignored.
REQ-024 For CALL with sp==STACK_DEPTH, the block SHALL not push, SHALL hold pc, SHALL set stack_ovf and SHALL enter FAULT.
REQ-025 For RET with sp>0, the block SHALL pop the top entry into pc and decrement sp.
REQ-026 For RET with sp==0, the block SHALL hold pc, SHALL set stack_udf and SHALL enter FAULT.
REQ-027 All updates SHALL take effect one cycle after the sampling edge, with no combinational path from any input to pc.
REQ-028 When err_clr=1 in FAULT, the block SHALL clear both flags and return to RUN on the next edge, and SHALL ignore adv on that cycle.
REQ-029 err_clr=1 in RUN SHALL clear the flags, and the op SHALL still execute normally.
REQ-030 A new error in the same cycle as err_clr SHALL take precedence, setting its flag and entering FAULT.

Reset
REQ-031 When rst_n=0 at a clock edge, the block SHALL set pc=0, sp=0, fault=0, stack_ovf=0, stack_udf=0 and state=RUN; reset has priority over all other inputs.
REQ-032 Return-stack entry contents need not be reset; sp=0 SHALL make them unobservable.
REQ-033 Reset asserted mid-CALL or mid-RET SHALL discard that operation entirely.

Structure
REQ-034 The op encodings, the FSM state enum and the instr_size default constant SHALL live in the shared package seq_pkg.
REQ-035 The return stack SHALL be the sub-module pc_return_stack, a parametrised LIFO with push, pop, full, empty and count outputs.
REQ-036 pc_return_stack SHALL reject a push when full and a pop when empty, leaving its contents and count unchanged.

Verification
REQ-037 Reset, then adv=1, op=NEXT with instr_size 1, 2, 3, 0 -> pc sequence 1, 3, 6, 7.
REQ-038 pc=0xFE, op=NEXT, size=3 -> pc=0x01; pc=0x10, op=BRANCH_REL, size=2, offset=0xF0, cond=1 -> pc=0x02; same with cond=0 -> pc=0x12.
REQ-039 Nested CALLs at pc 0x10 (size 3) to 0x40, then at 0x40 (size 2) to 0x80; then RET, RET -> pc=0x42, then 0x13, with sp going 1, 2, 1, 0.
REQ-040 STACK_DEPTH=4: five CALLs -> fifth gives stack_ovf=1, fault=1, pc and sp=4 held; err_clr=1 -> fault=0 next cycle; RET then pops the fourth return address.
REQ-041 RET at sp=0 -> stack_udf=1 and fault=1; adv pulses during FAULT leave pc unchanged.
REQ-042 rst_n=0 driven on the same edge as a CALL with adv=1 -> pc=0 and sp=0; adv=0 held for 5 cycles mid-program -> pc unchanged.
